// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: two-requester arbiter for the single register-file write port.
// req0 (ALU/writeback) and req1 (load/MDU) compete for one write per cycle; the
// winner is registered and presented on RFWr/A3/WD one cycle after acceptance.
// Optional busy-bit scoreboard enabled by defining RF_SCOREBOARD_EN; without it
// busy1/busy2 are tied low and the rsv_*/rd_addr* inputs are ignored.
module rf_wr_arbiter #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          RFWr,
    output logic [AW-1:0] A3,
    output logic [DW-1:0] WD,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          busy1,
    output logic          busy2
);

    // Which requester won the most recent contested cycle.
    typedef enum logic {
        LAST_REQ0 = 1'b0,
        LAST_REQ1 = 1'b1
    } grant_e;

    grant_e        last_grant;
    logic          both_valid;
    logic          gnt0;
    logic          gnt1;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_data;

    assign both_valid = req0_valid & req1_valid;
    assign gnt0       = req0_valid & req0_ready;
    assign gnt1       = req1_valid & req1_ready;

    // Ready generation from valids, flush and last_grant only.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!flush) begin
            if (both_valid) begin
                if (PRIO_MODE == 1 || last_grant == LAST_REQ1) begin
                    req0_ready = 1'b1;
                end else begin
                    req1_ready = 1'b1;
                end
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    // Select address/data of the granted requester.
    always_comb begin
        gnt_addr = req0_addr;
        gnt_data = req0_data;
        if (gnt1) begin
            gnt_addr = req1_addr;
            gnt_data = req1_data;
        end
    end

    // Output stage and round-robin history; writes to r0 are accepted but dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RFWr       <= 1'b0;
            A3         <= '0;
            WD         <= '0;
            last_grant <= LAST_REQ1;
        end else begin
            if ((gnt0 || gnt1) && both_valid) begin
                last_grant <= gnt0 ? LAST_REQ0 : LAST_REQ1;
            end
            if ((gnt0 || gnt1) && gnt_addr != '0) begin
                RFWr <= 1'b1;
                A3   <= gnt_addr;
                WD   <= gnt_data;
            end else begin
                RFWr <= 1'b0;
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    localparam int unsigned NREG = 1 << AW;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Next busy vector: clear on retiring write, then set on reservation so a
    // same-register set+clear leaves the bit set; flush wipes everything.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (RFWr) begin
                busy_nxt[A3] = 1'b0;
            end
            if (rsv_valid && rsv_addr != '0) begin
                busy_nxt[rsv_addr] = 1'b1;
            end
        end
    end

    // Busy-bit storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy1 = (rd_addr1 != '0) && busy[rd_addr1];
    assign busy2 = (rd_addr2 != '0) && busy[rd_addr2];
`else
    logic unused_sb_inputs;

    assign unused_sb_inputs = ^{rsv_valid, rsv_addr, rd_addr1, rd_addr2};
    assign busy1            = 1'b0;
    assign busy2            = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed testbench for rf_wr_arbiter: one round-robin and one fixed-priority
// instance share the stimulus. Scoreboard expectations follow RF_SCOREBOARD_EN.
module tb_rf_wr_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
`ifdef RF_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr, rd_addr1, rd_addr2;

    logic          rr_rdy0, rr_rdy1, rr_rfwr, rr_busy1, rr_busy2;
    logic [AW-1:0] rr_a3;
    logic [DW-1:0] rr_wd;
    logic          fp_rdy0, fp_rdy1, fp_rfwr, fp_busy1, fp_busy2;
    logic [AW-1:0] fp_a3;
    logic [DW-1:0] fp_wd;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_wr_arbiter #(.DW(DW), .AW(AW), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(rr_rdy0), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(rr_rdy1), .req1_addr(req1_addr), .req1_data(req1_data),
        .RFWr(rr_rfwr), .A3(rr_a3), .WD(rr_wd),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .busy1(rr_busy1), .busy2(rr_busy2)
    );

    rf_wr_arbiter #(.DW(DW), .AW(AW), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(fp_rdy0), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(fp_rdy1), .req1_addr(req1_addr), .req1_data(req1_data),
        .RFWr(fp_rfwr), .A3(fp_a3), .WD(fp_wd),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .busy1(fp_busy1), .busy2(fp_busy2)
    );

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        tests++; if (rr_rfwr !== 1'b0) begin failures++; $display("FAIL reset_rfwr: got %0h expected 0", rr_rfwr); end
        tests++; if (rr_busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1: got %0h expected 0", rr_busy1); end
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAA;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        tests++; if (rr_rfwr !== 1'b1) begin failures++; $display("FAIL pre_reset_rfwr: got %0h expected 1", rr_rfwr); end
        #2 rst = 1'b0;
        #1;
        tests++; if (rr_rfwr !== 1'b0) begin failures++; $display("FAIL async_reset_rfwr: got %0h expected 0", rr_rfwr); end
        tests++; if (rr_a3 !== 5'd0) begin failures++; $display("FAIL async_reset_a3: got %0h expected 0", rr_a3); end
        tests++; if (rr_wd !== 32'd0) begin failures++; $display("FAIL async_reset_wd: got %0h expected 0", rr_wd); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1234;
        #1;
        tests++; if (rr_rdy0 !== 1'b1) begin failures++; $display("FAIL single_ready0: got %0h expected 1", rr_rdy0); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        tests++; if (rr_rfwr !== 1'b1) begin failures++; $display("FAIL single_rfwr: got %0h expected 1", rr_rfwr); end
        tests++; if (rr_a3 !== 5'd5) begin failures++; $display("FAIL single_a3: got %0h expected 5", rr_a3); end
        tests++; if (rr_wd !== 32'h1234) begin failures++; $display("FAIL single_wd: got %0h expected 1234", rr_wd); end
        @(negedge clk);
        #1;
        tests++; if (rr_rfwr !== 1'b0) begin failures++; $display("FAIL single_rfwr_drop: got %0h expected 0", rr_rfwr); end
        tests++; if (rr_a3 !== 5'd5) begin failures++; $display("FAIL single_a3_hold: got %0h expected 5", rr_a3); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_a3;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA0;
            req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB0;
            #1;
            tests++; if (rr_rdy0 !== (k % 2 == 0)) begin failures++; $display("FAIL rr_ready0 k=%0d: got %0h expected %0h", k, rr_rdy0, (k % 2 == 0)); end
            tests++; if (rr_rdy1 !== (k % 2 == 1)) begin failures++; $display("FAIL rr_ready1 k=%0d: got %0h expected %0h", k, rr_rdy1, (k % 2 == 1)); end
            if (k > 0) begin
                exp_a3 = ((k - 1) % 2 == 0) ? 5'd1 : 5'd2;
                tests++; if (rr_rfwr !== 1'b1) begin failures++; $display("FAIL rr_rfwr k=%0d: got %0h expected 1", k, rr_rfwr); end
                tests++; if (rr_a3 !== exp_a3) begin failures++; $display("FAIL rr_a3 k=%0d: got %0h expected %0h", k, rr_a3, exp_a3); end
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        tests++; if (rr_rfwr !== 1'b1) begin failures++; $display("FAIL rr_rfwr_last: got %0h expected 1", rr_rfwr); end
        tests++; if (rr_a3 !== 5'd2) begin failures++; $display("FAIL rr_a3_last: got %0h expected 2", rr_a3); end
        tests++; if (rr_wd !== 32'hB0) begin failures++; $display("FAIL rr_wd_last: got %0h expected b0", rr_wd); end
        @(negedge clk);
        #1;
        tests++; if (rr_rfwr !== 1'b0) begin failures++; $display("FAIL rr_rfwr_idle: got %0h expected 0", rr_rfwr); end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hC3;
            req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hD4;
            #1;
            tests++; if (fp_rdy0 !== 1'b1) begin failures++; $display("FAIL fp_ready0 k=%0d: got %0h expected 1", k, fp_rdy0); end
            tests++; if (fp_rdy1 !== 1'b0) begin failures++; $display("FAIL fp_ready1 k=%0d: got %0h expected 0", k, fp_rdy1); end
            if (k > 0) begin
                tests++; if (fp_a3 !== 5'd3) begin failures++; $display("FAIL fp_a3 k=%0d: got %0h expected 3", k, fp_a3); end
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        #1;
        tests++; if (fp_rdy1 !== 1'b1) begin failures++; $display("FAIL fp_ready1_drop: got %0h expected 1", fp_rdy1); end
        tests++; if (fp_a3 !== 5'd3) begin failures++; $display("FAIL fp_a3_third: got %0h expected 3", fp_a3); end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        tests++; if (fp_rfwr !== 1'b1) begin failures++; $display("FAIL fp_rfwr_req1: got %0h expected 1", fp_rfwr); end
        tests++; if (fp_a3 !== 5'd4) begin failures++; $display("FAIL fp_a3_req1: got %0h expected 4", fp_a3); end
    endtask

    task automatic test_r0_flush();
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h77;
        #1;
        tests++; if (rr_rdy1 !== 1'b1) begin failures++; $display("FAIL r0_ready1: got %0h expected 1", rr_rdy1); end
        tests++; if (rr_a3 !== 5'd9) begin failures++; $display("FAIL r0_prev_a3: got %0h expected 9", rr_a3); end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        tests++; if (rr_rfwr !== 1'b0) begin failures++; $display("FAIL r0_rfwr: got %0h expected 0", rr_rfwr); end
        tests++; if (rr_a3 !== 5'd9) begin failures++; $display("FAIL r0_a3_hold: got %0h expected 9", rr_a3); end
        tests++; if (rr_wd !== 32'h99) begin failures++; $display("FAIL r0_wd_hold: got %0h expected 99", rr_wd); end
        flush = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
        #1;
        tests++; if (rr_rdy0 !== 1'b0) begin failures++; $display("FAIL flush_ready0: got %0h expected 0", rr_rdy0); end
        tests++; if (rr_rdy1 !== 1'b0) begin failures++; $display("FAIL flush_ready1: got %0h expected 0", rr_rdy1); end
        tests++; if (fp_rdy0 !== 1'b0) begin failures++; $display("FAIL flush_fp_ready0: got %0h expected 0", fp_rdy0); end
        @(negedge clk);
        flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        tests++; if (rr_rfwr !== 1'b0) begin failures++; $display("FAIL flush_rfwr: got %0h expected 0", rr_rfwr); end
        tests++; if (fp_rfwr !== 1'b0) begin failures++; $display("FAIL flush_fp_rfwr: got %0h expected 0", fp_rfwr); end
    endtask

    task automatic test_scoreboard();
        do_reset();
        rd_addr1 = 5'd7; rd_addr2 = 5'd8;
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        @(negedge clk);
        rsv_valid = 1'b0;
        #1;
        tests++; if (rr_busy1 !== SB) begin failures++; $display("FAIL sb_set_busy1: got %0h expected %0h", rr_busy1, SB); end
        tests++; if (rr_busy2 !== 1'b0) begin failures++; $display("FAIL sb_other_busy2: got %0h expected 0", rr_busy2); end
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h55;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        tests++; if (rr_rfwr !== 1'b1) begin failures++; $display("FAIL sb_write_rfwr: got %0h expected 1", rr_rfwr); end
        tests++; if (rr_busy1 !== SB) begin failures++; $display("FAIL sb_busy_during_write: got %0h expected %0h", rr_busy1, SB); end
        @(negedge clk);
        #1;
        tests++; if (rr_busy1 !== 1'b0) begin failures++; $display("FAIL sb_cleared: got %0h expected 0", rr_busy1); end
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h56;
        @(negedge clk);
        req0_valid = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        @(negedge clk);
        rsv_valid = 1'b0;
        #1;
        tests++; if (rr_busy1 !== SB) begin failures++; $display("FAIL sb_set_wins: got %0h expected %0h", rr_busy1, SB); end
        @(negedge clk);
        #1;
        tests++; if (rr_busy1 !== SB) begin failures++; $display("FAIL sb_set_holds: got %0h expected %0h", rr_busy1, SB); end
        flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd8;
        @(negedge clk);
        flush = 1'b0; rsv_valid = 1'b0;
        #1;
        tests++; if (rr_busy1 !== 1'b0) begin failures++; $display("FAIL sb_flush_busy1: got %0h expected 0", rr_busy1); end
        tests++; if (rr_busy2 !== 1'b0) begin failures++; $display("FAIL sb_flush_over_set: got %0h expected 0", rr_busy2); end
        rsv_valid = 1'b1; rsv_addr = 5'd0; rd_addr2 = 5'd0;
        @(negedge clk);
        rsv_valid = 1'b0;
        #1;
        tests++; if (rr_busy2 !== 1'b0) begin failures++; $display("FAIL sb_r0_busy: got %0h expected 0", rr_busy2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fixed_prio();
        test_r0_flush();
        test_scoreboard();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
